syn_run_controller: RTL and testbench

Run controller that sequences the single-cycle CPU core by driving its global `en`. Accepts run/step/pause commands from board buttons or a host and an optional PC breakpoint, reacts to the core's `halt`, and can throttle execution with a divided enable rate. Counts retired instructions, jumps, branches and taken branches from the core's `jumped`/`is_branch`/`branched` outputs. Sits between the board top level and the CPU top module.

---
 rtl/syn_run_controller.sv | 117 +++++++++++
 tb/tb_syn_run_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_run_controller.sv
// syn_run_controller: run/step/pause sequencer driving the core enable, with throttling, optional PC breakpoint (RUNCTL_BREAKPOINT_EN) and retire statistics.
// Ports: clk, rst (sync active-high); cmd_run/cmd_step/cmd_pause pulses; rate_sel (1 = divided rate);
//   stat_clr; bp_en/bp_addr breakpoint; pc_dbg core PC; halt, jumped, is_branch, branched core flags;
//   cpu_en core enable; state (IDLE=0, RUN=1, STEP=2, HALTED=3); bp_hit sticky; cnt_* statistics.
module syn_run_controller #(
  parameter int CntWidth = 32,
  parameter int DivBits  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_run,
  input  logic                cmd_step,
  input  logic                cmd_pause,
  input  logic                rate_sel,
  input  logic                stat_clr,
  input  logic                bp_en,
  input  logic [31:0]         bp_addr,
  input  logic [31:0]         pc_dbg,
  input  logic                halt,
  input  logic                jumped,
  input  logic                is_branch,
  input  logic                branched,
  output logic                cpu_en,
  output logic [1:0]          state,
  output logic                bp_hit,
  output logic [CntWidth-1:0] cnt_inst,
  output logic [CntWidth-1:0] cnt_jump,
  output logic [CntWidth-1:0] cnt_branch,
  output logic [CntWidth-1:0] cnt_taken
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;
  state_t state_q, state_d;
  logic [DivBits-1:0] div_q, div_d;
  logic [CntWidth-1:0] cnt_inst_q, cnt_inst_d, cnt_jump_q, cnt_jump_d;
  logic [CntWidth-1:0] cnt_branch_q, cnt_branch_d, cnt_taken_q, cnt_taken_d;
  logic tick, bp_match;
`ifdef RUNCTL_BREAKPOINT_EN
  logic skip_q, skip_d, bp_hit_q, bp_hit_d;
  // skip lets the instruction we stopped on execute once after resuming
  assign bp_match = state_q == RUN && bp_en && pc_dbg == bp_addr && !skip_q;
  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc_dbg};
  assign bp_match = 1'b0;
  assign bp_hit = 1'b0;
`endif
  assign tick = !rate_sel || div_q == '0;
  assign cpu_en = !halt && (state_q == STEP || (state_q == RUN && tick && !bp_match));
  assign state = state_q;
  assign cnt_inst = cnt_inst_q;
  assign cnt_jump = cnt_jump_q;
  assign cnt_branch = cnt_branch_q;
  assign cnt_taken = cnt_taken_q;
  always_comb begin
    state_d = state_q;
    div_d = div_q;
`ifdef RUNCTL_BREAKPOINT_EN
    skip_d = skip_q;
    bp_hit_d = bp_hit_q;
`endif
    if (halt) state_d = HALTED;
    else case (state_q)
      IDLE: begin
        if (!cmd_pause && (cmd_step || cmd_run)) begin
          state_d = cmd_step ? STEP : RUN;
          div_d = '0;
`ifdef RUNCTL_BREAKPOINT_EN
          bp_hit_d = 1'b0;
          skip_d = 1'b1;
`endif
        end
      end
      RUN: begin
        div_d = div_q + DivBits'(1);
        if (bp_match || cmd_pause) state_d = IDLE;
`ifdef RUNCTL_BREAKPOINT_EN
        bp_hit_d = bp_hit_q | bp_match;
        skip_d = skip_q && !cpu_en;
`endif
      end
      STEP: state_d = IDLE;
      default: state_d = HALTED;
    endcase
  end
  always_comb begin
    cnt_inst_d = stat_clr ? '0 : cpu_en ? cnt_inst_q + CntWidth'(1) : cnt_inst_q;
    cnt_jump_d = stat_clr ? '0 : cpu_en ? cnt_jump_q + CntWidth'(jumped) : cnt_jump_q;
    cnt_branch_d = stat_clr ? '0 : cpu_en ? cnt_branch_q + CntWidth'(is_branch) : cnt_branch_q;
    cnt_taken_d = stat_clr ? '0 : cpu_en ? cnt_taken_q + CntWidth'(branched) : cnt_taken_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      cnt_inst_q <= '0;
      cnt_jump_q <= '0;
      cnt_branch_q <= '0;
      cnt_taken_q <= '0;
`ifdef RUNCTL_BREAKPOINT_EN
      skip_q <= 1'b0;
      bp_hit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      cnt_inst_q <= cnt_inst_d;
      cnt_jump_q <= cnt_jump_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q <= cnt_taken_d;
`ifdef RUNCTL_BREAKPOINT_EN
      skip_q <= skip_d;
      bp_hit_q <= bp_hit_d;
`endif
    end
  end
endmodule

// File: tb/tb_syn_run_controller.sv
// tb_syn_run_controller: scoreboard bench for syn_run_controller; queue holds the PC expected at each core enable.
module tb_syn_run_controller;
`ifdef RUNCTL_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_run = 0, cmd_step = 0, cmd_pause = 0, rate_sel = 0, stat_clr = 0, bp_en = 0;
  logic [31:0] bp_addr = 0, pc_dbg = 0;
  logic halt = 0, jumped = 0, is_branch = 0, branched = 0;
  logic cpu_en, bp_hit;
  logic [1:0] state;
  logic [31:0] cnt_inst, cnt_jump, cnt_branch, cnt_taken;
  logic [31:0] sb[$];
  logic [31:0] sb_exp;
  int checks = 0, errors = 0;

  syn_run_controller #(.CntWidth(32), .DivBits(4)) dut (
    .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_pause(cmd_pause),
    .rate_sel(rate_sel), .stat_clr(stat_clr), .bp_en(bp_en), .bp_addr(bp_addr), .pc_dbg(pc_dbg),
    .halt(halt), .jumped(jumped), .is_branch(is_branch), .branched(branched), .cpu_en(cpu_en),
    .state(state), .bp_hit(bp_hit), .cnt_inst(cnt_inst), .cnt_jump(cnt_jump),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && cpu_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_en pc got %0h exp no enable", pc_dbg);
      end else begin
        sb_exp = sb.pop_front();
        if (pc_dbg !== sb_exp) begin
          errors++;
          $display("FAIL en_pc got %0h exp %0h", pc_dbg, sb_exp);
        end
      end
    end
  end

  // c = {run, step, pause, clr}, f = {halt, jumped, is_branch, branched}
  task automatic cyc(input logic [3:0] c, input logic [31:0] pc, input logic [3:0] f);
    @(posedge clk);
    #1;
    {cmd_run, cmd_step, cmd_pause, stat_clr} = c;
    pc_dbg = pc;
    {halt, jumped, is_branch, branched} = f;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) cyc(4'b0000, 0, 4'b0000);
    checks++;
    if ({state, cpu_en, bp_hit} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got %b exp 0000", {state, cpu_en, bp_hit});
    end
    checks++;
    if ({cnt_inst, cnt_jump, cnt_branch, cnt_taken} !== 128'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0h exp 0", {cnt_inst, cnt_jump, cnt_branch, cnt_taken});
    end
    rst = 1'b0;
  endtask

  task automatic test_run_full;
    cyc(4'b1000, 0, 4'b0000);
    checks++;
    if ({state, cpu_en} !== 3'b000) begin
      errors++;
      $display("FAIL run_cmd_cycle got %b exp 000", {state, cpu_en});
    end
    for (int i = 0; i < 10; i++) begin
      sb.push_back(32'(i * 4));
      cyc(4'b0000, 32'(i * 4), {2'b00, (i % 2) == 1, i == 3});
      checks++;
      if ({state, cpu_en} !== 3'b011) begin
        errors++;
        $display("FAIL run_full_en i=%0d got %b exp 011", i, {state, cpu_en});
      end
    end
    sb.push_back(40);
    cyc(4'b0010, 40, 4'b0000);
    checks++;
    if ({cnt_inst, cnt_jump, cnt_branch, cnt_taken, cpu_en} !== {32'd10, 32'd0, 32'd5, 32'd1, 1'b1}) begin
      errors++;
      $display("FAIL run_full_cnt got %0d/%0d/%0d/%0d en %b exp 10/0/5/1 en 1", cnt_inst, cnt_jump, cnt_branch, cnt_taken, cpu_en);
    end
    cyc(4'b0000, 44, 4'b0000);
    checks++;
    if ({state, cpu_en, cnt_inst} !== {3'b000, 32'd11}) begin
      errors++;
      $display("FAIL pause_idle got st %0d en %b cnt %0d exp 0 0 11", state, cpu_en, cnt_inst);
    end
  endtask

  task automatic test_slow;
    int pulses = 0;
    logic e;
    cyc(4'b0001, 0, 4'b0000);
    rate_sel = 1'b1;
    cyc(4'b1000, 0, 4'b0000);
    checks++;
    if (cnt_inst !== 32'd0) begin
      errors++;
      $display("FAIL clr_idle got %0d exp 0", cnt_inst);
    end
    for (int i = 0; i < 64; i++) begin
      e = (i % 16) == 0;
      if (e) sb.push_back(32'(i));
      cyc(4'b0000, 32'(i), 4'b0000);
      pulses += int'(cpu_en);
      checks++;
      if (cpu_en !== e) begin
        errors++;
        $display("FAIL slow_en k=%0d got %b exp %b", i, cpu_en, e);
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL slow_pulses got %0d exp 4", pulses);
    end
    sb.push_back(64);
    cyc(4'b0010, 64, 4'b0000);
    checks++;
    if ({cnt_inst, cpu_en} !== {32'd4, 1'b1}) begin
      errors++;
      $display("FAIL slow_cnt got %0d en %b exp 4 en 1", cnt_inst, cpu_en);
    end
    cyc(4'b0000, 65, 4'b0000);
    rate_sel = 1'b0;
  endtask

  task automatic test_breakpoint;
    cyc(4'b0001, 0, 4'b0000);
    bp_en = 1'b1;
    bp_addr = 32'h0C;
    cyc(4'b1000, 0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'(i * 4));
      cyc(4'b0000, 32'(i * 4), 4'b0000);
      checks++;
      if (cpu_en !== 1'b1) begin
        errors++;
        $display("FAIL bp_pre_en pc=%0h got %b exp 1", i * 4, cpu_en);
      end
    end
    if (!BP_ON) sb.push_back(32'h0C);
    cyc(4'b0000, 32'h0C, 4'b0000);
    checks++;
    if ({state, cpu_en} !== {2'd1, !BP_ON}) begin
      errors++;
      $display("FAIL bp_stop got %b exp %b", {state, cpu_en}, {2'd1, !BP_ON});
    end
    if (!BP_ON) sb.push_back(32'h10);
    cyc(4'b0010, BP_ON ? 32'h0C : 32'h10, 4'b0000);
    checks++;
    if ({state, bp_hit} !== {BP_ON ? 2'd0 : 2'd1, BP_ON}) begin
      errors++;
      $display("FAIL bp_hit_set got %b exp %b", {state, bp_hit}, {BP_ON ? 2'd0 : 2'd1, BP_ON});
    end
    cyc(4'b1000, 32'h0C, 4'b0000);
    checks++;
    if ({state, cpu_en, bp_hit, cnt_inst} !== {3'b000, BP_ON, BP_ON ? 32'd3 : 32'd5}) begin
      errors++;
      $display("FAIL bp_idle got st %0d en %b hit %b cnt %0d", state, cpu_en, bp_hit, cnt_inst);
    end
    sb.push_back(32'h0C);
    cyc(4'b0010, 32'h0C, 4'b0000);
    checks++;
    if ({state, cpu_en, bp_hit} !== 4'b0110) begin
      errors++;
      $display("FAIL bp_resume got %b exp 0110", {state, cpu_en, bp_hit});
    end
    cyc(4'b0000, 32'h10, 4'b0000);
    checks++;
    if ({state, cnt_inst} !== {2'd0, BP_ON ? 32'd4 : 32'd6}) begin
      errors++;
      $display("FAIL bp_resume_cnt got st %0d cnt %0d exp 0 %0d", state, cnt_inst, BP_ON ? 4 : 6);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_pause_step;
    cyc(4'b0001, 0, 4'b0000);
    cyc(4'b0110, 32'h20, 4'b0000);
    bp_en = 1'b1;
    bp_addr = 32'h20;
    cyc(4'b0100, 32'h20, 4'b0000);
    checks++;
    if ({state, cpu_en} !== 3'b000) begin
      errors++;
      $display("FAIL pause_over_step got %b exp 000", {state, cpu_en});
    end
    sb.push_back(32'h20);
    cyc(4'b0000, 32'h20, 4'b0100);
    checks++;
    if ({state, cpu_en, bp_hit} !== 4'b1010) begin
      errors++;
      $display("FAIL step_en got %b exp 1010", {state, cpu_en, bp_hit});
    end
    cyc(4'b0000, 32'h24, 4'b0000);
    checks++;
    if ({state, cpu_en, cnt_inst, cnt_jump} !== {3'b000, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL step_done got st %0d en %b inst %0d jump %0d exp 0 0 1 1", state, cpu_en, cnt_inst, cnt_jump);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_stat_clr;
    cyc(4'b0001, 0, 4'b0000);
    cyc(4'b1000, 0, 4'b0000);
    sb.push_back(0);
    cyc(4'b0000, 0, 4'b0111);
    sb.push_back(4);
    cyc(4'b0000, 4, 4'b0111);
    checks++;
    if ({cnt_inst, cnt_jump, cnt_branch, cnt_taken} !== {4{32'd1}}) begin
      errors++;
      $display("FAIL flags_cnt got %0d/%0d/%0d/%0d exp 1/1/1/1", cnt_inst, cnt_jump, cnt_branch, cnt_taken);
    end
    sb.push_back(8);
    cyc(4'b0001, 8, 4'b0111);
    sb.push_back(12);
    cyc(4'b0010, 12, 4'b0000);
    checks++;
    if ({cnt_inst, cnt_jump, cnt_branch, cnt_taken} !== 128'd0) begin
      errors++;
      $display("FAIL clr_override got %0d/%0d/%0d/%0d exp 0/0/0/0", cnt_inst, cnt_jump, cnt_branch, cnt_taken);
    end
    cyc(4'b0000, 16, 4'b0000);
    checks++;
    if ({state, cnt_inst, cnt_branch} !== {2'd0, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL clr_after got st %0d inst %0d br %0d exp 0 1 0", state, cnt_inst, cnt_branch);
    end
  endtask

  task automatic test_halt;
    cyc(4'b1000, 0, 4'b0000);
    sb.push_back(0);
    cyc(4'b0000, 0, 4'b0000);
    sb.push_back(4);
    cyc(4'b0000, 4, 4'b0000);
    cyc(4'b0000, 8, 4'b1000);
    checks++;
    if ({state, cpu_en} !== 3'b010) begin
      errors++;
      $display("FAIL halt_same got %b exp 010", {state, cpu_en});
    end
    cyc(4'b1000, 8, 4'b1000);
    checks++;
    if ({state, cpu_en} !== 3'b110) begin
      errors++;
      $display("FAIL halted got %b exp 110", {state, cpu_en});
    end
    cyc(4'b0100, 8, 4'b0000);
    cyc(4'b1000, 8, 4'b0000);
    checks++;
    if ({state, cpu_en} !== 3'b110) begin
      errors++;
      $display("FAIL halted_ignore got %b exp 110", {state, cpu_en});
    end
    rst = 1'b1;
    cyc(4'b0000, 8, 4'b0000);
    rst = 1'b0;
    checks++;
    if ({state, cpu_en, cnt_inst} !== {3'b000, 32'd0}) begin
      errors++;
      $display("FAIL halt_rst got st %0d en %b cnt %0d exp 0 0 0", state, cpu_en, cnt_inst);
    end
    cyc(4'b1000, 0, 4'b0000);
    sb.push_back(0);
    cyc(4'b0010, 0, 4'b0000);
    checks++;
    if ({state, cpu_en} !== 3'b011) begin
      errors++;
      $display("FAIL rerun got %b exp 011", {state, cpu_en});
    end
    cyc(4'b0000, 4, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_run_full();
    test_slow();
    test_breakpoint();
    test_pause_step();
    test_stat_clr();
    test_halt();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_en got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
